// File: rtl/floor_request_latch.sv
// Button front end: synchronises and debounces each button, then latches presses until the floor is served.
// Optional macro REQ_CANCEL_EN: a second press on an already-pending floor cancels that request.
module floor_request_latch #(
  parameter int NUM_FLOORS = 16,
  parameter int DB_CYCLES  = 4,
  parameter int DB_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] raw_buttons,
  input  logic [3:0]            current_floor,
  input  logic                  floor_served,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  any_pending,
  output logic                  new_req
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

  logic [NUM_FLOORS-1:0] s1_q, s2_q;
  logic [NUM_FLOORS-1:0] db_q, db_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] press, clr;
  logic [DB_W-1:0]       cnt_q [NUM_FLOORS];
  logic [DB_W-1:0]       cnt_d [NUM_FLOORS];
  logic                  new_req_q, new_req_d;

  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_bit
      logic differ;
      logic at_max;
      logic toggle;

      // The counter only runs while the synchronised level disagrees with the debounced one.
      assign differ     = s2_q[gi] ^ db_q[gi];
      assign at_max     = (cnt_q[gi] == CNT_MAX);
      assign toggle     = differ & at_max;
      assign press[gi]  = toggle & s2_q[gi];
      assign db_d[gi]   = toggle ? s2_q[gi] : db_q[gi];
      assign cnt_d[gi]  = (!differ || at_max) ? '0 : cnt_q[gi] + DB_W'(1);
      assign clr[gi]    = floor_served && (current_floor == 4'(gi));

      // Clear has priority: a press at the floor being served is already satisfied.
      always_comb begin
        pending_d[gi] = pending_q[gi];
        if (clr[gi]) begin
          pending_d[gi] = 1'b0;
        end else if (press[gi] && !pending_q[gi]) begin
          pending_d[gi] = 1'b1;
        end else if (press[gi] && pending_q[gi]) begin
`ifdef REQ_CANCEL_EN
          pending_d[gi] = 1'b0;
`else
          pending_d[gi] = 1'b1;
`endif
        end
      end
    end
  endgenerate

  assign new_req_d = |(pending_d & ~pending_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      pending_q <= '0;
      new_req_q <= 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw_buttons;
      s2_q      <= s1_q;
      db_q      <= db_d;
      pending_q <= pending_d;
      new_req_q <= new_req_d;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pending     = pending_q;
  assign any_pending = |pending_q;
  assign new_req     = new_req_q;

endmodule

// File: tb/tb_floor_request_latch.sv
// Self-checking bench for floor_request_latch (NUM_FLOORS=16, DB_CYCLES=4) using a vector table and a scoreboard queue.
module tb_floor_request_latch;

  logic        clk;
  logic        reset;
  logic [15:0] raw_buttons;
  logic [3:0]  current_floor;
  logic        floor_served;
  logic [15:0] pending;
  logic        any_pending;
  logic        new_req;

  floor_request_latch #(.NUM_FLOORS(16), .DB_CYCLES(4), .DB_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_buttons  (raw_buttons),
    .current_floor(current_floor),
    .floor_served (floor_served),
    .pending      (pending),
    .any_pending  (any_pending),
    .new_req      (new_req)
  );

  typedef struct {
    string       name;
    logic [15:0] raw;
    logic [3:0]  floor;
    logic        served;
    int          edges;
    logic [15:0] exp_pend;
    logic        exp_new;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] pend;
    logic        any;
    logic        nreq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

`ifdef REQ_CANCEL_EN
  localparam logic [15:0] P9 = 16'h0000;
`else
  localparam logic [15:0] P9 = 16'h0200;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] pend, input logic nreq);
    exp_t e;
    e.name = name;
    e.pend = pend;
    e.any  = |pend;
    e.nreq = nreq;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (pending !== e.pend || any_pending !== e.any || new_req !== e.nreq) begin
      n_fail++;
      $display("FAIL %s: got pending=%h any=%b new=%b, required pending=%h any=%b new=%b",
               e.name, pending, any_pending, new_req, e.pend, e.any, e.nreq);
    end else begin
      $display("ok   %s: pending=%h any=%b new=%b", e.name, pending, any_pending, new_req);
    end
  endtask

  task automatic add(input string name, input logic [15:0] raw, input logic [3:0] floor,
                     input logic served, input int edges, input logic [15:0] exp_pend,
                     input logic exp_new);
    vec_t v;
    v.name = name; v.raw = raw; v.floor = floor; v.served = served;
    v.edges = edges; v.exp_pend = exp_pend; v.exp_new = exp_new;
    vecs.push_back(v);
  endtask

  initial begin
    // Held-in-reset with every button pressed
    reset = 1'b0; raw_buttons = 16'hFFFF; current_floor = 4'd0; floor_served = 1'b0;
    tick(3);
    expect_out("reset_hold", 16'h0000, 1'b0); check_out();
    reset = 1'b1;
    tick(5);
    expect_out("reset_release_e5", 16'h0000, 1'b0); check_out();
    tick(1);
    expect_out("reset_release_e6", 16'hFFFF, 1'b1); check_out();
    tick(1);
    expect_out("reset_release_e7", 16'hFFFF, 1'b0); check_out();

    // Asynchronous reset mid-debounce (release in progress) with requests pending
    raw_buttons = 16'h0000;
    tick(3);
    expect_out("pre_async", 16'hFFFF, 1'b0); check_out();
    #3 reset = 1'b0;
    #1;
    expect_out("async_reset", 16'h0000, 1'b0); check_out();
    tick(1);
    reset = 1'b1;
    tick(8);
    expect_out("post_reset_idle", 16'h0000, 1'b0); check_out();

    add("lat_e5",        16'h0020, 4'd0, 1'b0, 5, 16'h0020 & 16'h0000, 1'b0);
    add("lat_e6",        16'h0020, 4'd0, 1'b0, 1, 16'h0020, 1'b1);
    add("lat_e7",        16'h0020, 4'd0, 1'b0, 1, 16'h0020, 1'b0);
    add("glitch_high",   16'h0028, 4'd0, 1'b0, 3, 16'h0020, 1'b0);
    add("glitch_after",  16'h0020, 4'd0, 1'b0, 6, 16'h0020, 1'b0);
    add("press_b2",      16'h0024, 4'd0, 1'b0, 6, 16'h0024, 1'b1);
    add("serve_f2",      16'h0024, 4'd2, 1'b1, 1, 16'h0020, 1'b0);
    add("serve_f2_idle", 16'h0024, 4'd2, 1'b0, 1, 16'h0020, 1'b0);
    add("serve_f5",      16'h0024, 4'd5, 1'b1, 1, 16'h0000, 1'b0);
    add("serve_f5_idle", 16'h0024, 4'd5, 1'b0, 1, 16'h0000, 1'b0);
    add("release_25",    16'h0000, 4'd0, 1'b0, 8, 16'h0000, 1'b0);
    add("collide_pre",   16'h0080, 4'd7, 1'b0, 5, 16'h0000, 1'b0);
    add("collide",       16'h0080, 4'd7, 1'b1, 1, 16'h0000, 1'b0);
    add("collide_after", 16'h0080, 4'd7, 1'b0, 1, 16'h0000, 1'b0);
    add("release_7",     16'h0000, 4'd0, 1'b0, 8, 16'h0000, 1'b0);
    add("press_b9",      16'h0200, 4'd0, 1'b0, 6, 16'h0200, 1'b1);
    add("release_9",     16'h0000, 4'd0, 1'b0, 8, 16'h0200, 1'b0);
    add("repress_b9",    16'h0200, 4'd0, 1'b0, 6, P9, 1'b0);
    add("release_9b",    16'h0000, 4'd0, 1'b0, 8, P9, 1'b0);
    add("multi_press",   16'h8001, 4'd0, 1'b0, 6, P9 | 16'h8001, 1'b1);
    add("pulse4_high",   16'h8011, 4'd0, 1'b0, 4, P9 | 16'h8001, 1'b0);
    add("pulse4_accept", 16'h8001, 4'd0, 1'b0, 2, P9 | 16'h8011, 1'b1);
    add("pulse4_after",  16'h8001, 4'd0, 1'b0, 1, P9 | 16'h8011, 1'b0);
    add("serve_f15",     16'h0000, 4'd15, 1'b1, 1, P9 | 16'h0011, 1'b0);
    add("serve_f0",      16'h0000, 4'd0, 1'b1, 1, P9 | 16'h0010, 1'b0);
    add("serve_f4",      16'h0000, 4'd4, 1'b1, 1, P9, 1'b0);
    add("serve_f9",      16'h0000, 4'd9, 1'b1, 1, 16'h0000, 1'b0);
    add("final_idle",    16'h0000, 4'd0, 1'b0, 8, 16'h0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      raw_buttons   = vecs[i].raw;
      current_floor = vecs[i].floor;
      floor_served  = vecs[i].served;
      expect_out(vecs[i].name, vecs[i].exp_pend, vecs[i].exp_new);
      tick(vecs[i].edges);
      check_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
